// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Brief    : Shared constants and state encodings for the 8x8 LED matrix
//            scan driver. Pixel storage width follows MATRIX_PWM_EN
//            (4-bit intensity when defined, 1-bit lit flag otherwise).
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int MATRIX_DIM = 8;
    localparam int PIX_IDX_W  = 6;
    localparam int PWM_PHASES = 16;
    localparam int NUM_PIX    = MATRIX_DIM * MATRIX_DIM;

`ifdef MATRIX_PWM_EN
    localparam int PIX_W = 4;
`else
    localparam int PIX_W = 1;
`endif

    // Flattened frame buffer: pixel k occupies bits [k*PIX_W +: PIX_W]
    localparam int BUF_W = NUM_PIX * PIX_W;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_GAP  = 2'd1,
        CAP_RUN  = 2'd2
    } cap_state_t;

    typedef enum logic [0:0] {
        SCAN_BLANK = 1'b0,
        SCAN_ON    = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : matrix_frame_capture
// Brief    : Receives frame_start + 64 serial pixels into the back buffer and
//            flags a completed frame (swap_pending) for the scan side.
//            Storage width follows MATRIX_PWM_EN via matrix_pkg.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_frame_capture
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [3:0]       pixel_data,
    input  logic             swap_take,
    output logic             swap_pending,
    output logic             capture_busy,
    output logic [BUF_W-1:0] back_buf
);

    localparam logic [PIX_IDX_W-1:0] c_last_idx = PIX_IDX_W'(NUM_PIX - 1);

    cap_state_t           r_state;
    cap_state_t           w_next_state;
    logic [PIX_IDX_W-1:0] r_idx;
    logic [PIX_W-1:0]     w_pix;
    logic                 w_last;

`ifdef MATRIX_PWM_EN
    assign w_pix = pixel_data;
`else
    assign w_pix = (pixel_data != 4'd0);
`endif

    assign w_last = (r_state == CAP_RUN) && (r_idx == c_last_idx);

    // Capture state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CAP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: frame_start always (re)starts at the gap cycle
    always_comb begin
        w_next_state = r_state;
        if (frame_start) begin
            w_next_state = CAP_GAP;
        end else begin
            case (r_state)
                CAP_GAP:  w_next_state = CAP_RUN;
                CAP_RUN:  if (w_last) w_next_state = CAP_IDLE;
                default:  w_next_state = CAP_IDLE;
            endcase
        end
    end

    // Pixel write, busy flag and completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            back_buf     <= '0;
            capture_busy <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (frame_start) begin
                r_idx        <= '0;
                capture_busy <= 1'b1;
            end else if (r_state == CAP_RUN) begin
                back_buf[int'(r_idx)*PIX_W +: PIX_W] <= w_pix;
                r_idx <= r_idx + 1'b1;
                if (w_last) begin
                    capture_busy <= 1'b0;
                end
            end

            // A new start discards any finished-but-unshown frame
            if (frame_start) begin
                swap_pending <= 1'b0;
            end else if (w_last) begin
                swap_pending <= 1'b1;
            end else if (swap_take) begin
                swap_pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_driver
// Brief    : Captures a 64-pixel stream into a back buffer, swaps it to the
//            front buffer only at the scan-frame boundary, and row-multiplexes
//            the front buffer onto an 8x8 LED matrix with blanking.
//            Optional feature macro: MATRIX_PWM_EN (16-phase intensity PWM).
// Revision : 1.0 - initial release
// ============================================================================
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 64,
    parameter int BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [3:0] pixel_data,
    output logic [7:0] row_sel,
    output logic [7:0] col_data,
    output logic       frame_swapped,
    output logic       capture_busy
);

    localparam int                 c_cnt_w      = $clog2(DWELL_CYCLES + BLANK_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
    localparam logic [2:0]         c_last_row   = 3'(MATRIX_DIM - 1);

    scan_state_t            r_state;
    scan_state_t            w_next_state;
    logic [2:0]             r_row;
    logic [2:0]             w_next_row;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_next_cnt;

    logic [BUF_W-1:0]       r_front;
    logic [BUF_W-1:0]       w_back_buf;
    logic                   w_swap_pending;
    logic                   w_boundary;
    logic                   w_swap_take;
    logic [MATRIX_DIM-1:0]  w_row_sel_d;
    logic [MATRIX_DIM-1:0]  w_col_data_d;

`ifdef MATRIX_PWM_EN
    localparam int                   c_slice_len  = DWELL_CYCLES / PWM_PHASES;
    localparam int                   c_slice_w    = (c_slice_len > 1) ? $clog2(c_slice_len) : 1;
    localparam logic [c_slice_w-1:0] c_slice_last = c_slice_w'(c_slice_len - 1);

    logic [c_slice_w-1:0] r_slice;
    logic [c_slice_w-1:0] w_next_slice;
    logic [3:0]           r_phase;
    logic [3:0]           w_next_phase;
`endif

    matrix_frame_capture u_capture (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .pixel_data   (pixel_data),
        .swap_take    (w_swap_take),
        .swap_pending (w_swap_pending),
        .capture_busy (capture_busy),
        .back_buf     (w_back_buf)
    );

    // Last dwell clock of row 7: the edge that enters row 0 blanking
    assign w_boundary  = (r_state == SCAN_ON) && (r_row == c_last_row) && (r_cnt == c_dwell_last);
    // A capture start on the boundary edge cancels the swap
    assign w_swap_take = w_boundary && w_swap_pending && !frame_start;

    // Scan state register (state, row, cycle counter, PWM phase)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SCAN_BLANK;
            r_row   <= '0;
            r_cnt   <= '0;
`ifdef MATRIX_PWM_EN
            r_slice <= '0;
            r_phase <= '0;
`endif
        end else begin
            r_state <= w_next_state;
            r_row   <= w_next_row;
            r_cnt   <= w_next_cnt;
`ifdef MATRIX_PWM_EN
            r_slice <= w_next_slice;
            r_phase <= w_next_phase;
`endif
        end
    end

    // Next-state: BLANK_CYCLES of blanking, then DWELL_CYCLES lit, per row
    always_comb begin
        w_next_state = r_state;
        w_next_row   = r_row;
        w_next_cnt   = r_cnt + 1'b1;
        case (r_state)
            SCAN_BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_next_state = SCAN_ON;
                    w_next_cnt   = '0;
                end
            end
            SCAN_ON: begin
                if (r_cnt == c_dwell_last) begin
                    w_next_state = SCAN_BLANK;
                    w_next_cnt   = '0;
                    w_next_row   = r_row + 3'd1;
                end
            end
            default: begin
                w_next_state = SCAN_BLANK;
                w_next_cnt   = '0;
            end
        endcase
    end

`ifdef MATRIX_PWM_EN
    // PWM phase advances every DWELL_CYCLES/16 clocks within a lit row
    always_comb begin
        w_next_slice = '0;
        w_next_phase = '0;
        if ((r_state == SCAN_ON) && (w_next_state == SCAN_ON)) begin
            if (r_slice == c_slice_last) begin
                w_next_slice = '0;
                w_next_phase = r_phase + 4'd1;
            end else begin
                w_next_slice = r_slice + 1'b1;
                w_next_phase = r_phase;
            end
        end
    end
`endif

    // Output decode from the upcoming state so the registered pins line up with it
    always_comb begin
        w_row_sel_d  = '0;
        w_col_data_d = '0;
        if (w_next_state == SCAN_ON) begin
            w_row_sel_d = MATRIX_DIM'(1) << w_next_row;
            for (int x = 0; x < MATRIX_DIM; x++) begin
`ifdef MATRIX_PWM_EN
                w_col_data_d[x] = (r_front[(int'(w_next_row)*MATRIX_DIM + x)*PIX_W +: PIX_W] > w_next_phase);
`else
                w_col_data_d[x] = r_front[int'(w_next_row)*MATRIX_DIM + x];
`endif
            end
        end
    end

    // Registered matrix pins and front-buffer swap at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front       <= '0;
            row_sel       <= '0;
            col_data      <= '0;
            frame_swapped <= 1'b0;
        end else begin
            row_sel       <= w_row_sel_d;
            col_data      <= w_col_data_d;
            frame_swapped <= w_swap_take;
            if (w_swap_take) begin
                r_front <= w_back_buf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan_driver
// Brief    : Self-checking bench for matrix_scan_driver (DWELL=64, BLANK=1).
//            Reset-scan vector table, captured images queued and checked
//            against the displayed frame after each swap, plus abort,
//            mid-frame completion, boundary coincidence, reset and PWM cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_driver;

    localparam int DWELL = 64;
    localparam int BLANK = 1;
    localparam int ROWP  = DWELL + BLANK;
    localparam int FRAME = 8 * ROWP;
    localparam int SLICE = DWELL / 16;

    typedef logic [255:0] img_t;
    typedef struct {
        int         e;
        logic [7:0] rs;
        logic [7:0] cd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic [3:0] pixel_data;
    logic [7:0] row_sel;
    logic [7:0] col_data;
    logic       frame_swapped;
    logic       capture_busy;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   ecnt;
    int   swap_cnt = 0;
    img_t q[$];
    img_t shown;

    matrix_scan_driver #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .pixel_data    (pixel_data),
        .row_sel       (row_sel),
        .col_data      (col_data),
        .frame_swapped (frame_swapped),
        .capture_busy  (capture_busy)
    );

    always #5 clk = ~clk;

    // Edges since reset release: after edge n, ecnt == n
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    always @(posedge clk) begin
        if (frame_swapped) swap_cnt <= swap_cnt + 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected pins after edge e, derived from the scan timing
    task automatic exp_out(input img_t img, input int e, output logic [7:0] rs, output logic [7:0] cd);
        int pos, row, w, phase;
        logic [3:0] v;
        pos = e % FRAME;
        row = pos / ROWP;
        w   = pos % ROWP;
        rs  = 8'h00;
        cd  = 8'h00;
        if (w >= BLANK) begin
            rs    = 8'h01 << row;
            phase = (w - BLANK) / SLICE;
            for (int x = 0; x < 8; x++) begin
                v = img[(row*8 + x)*4 +: 4];
`ifdef MATRIX_PWM_EN
                cd[x] = (int'(v) > phase);
`else
                cd[x] = (v != 4'd0);
`endif
            end
        end
    endtask

    task automatic check_span(input img_t img, input int ncyc, input string tag);
        logic [7:0]  ers, ecd;
        bit          touched[8];
        bit          bad[8];
        logic [15:0] fa[8];
        logic [15:0] fe[8];
        int          row;
        for (int r = 0; r < 8; r++) begin
            touched[r] = 0; bad[r] = 0; fa[r] = '0; fe[r] = '0;
        end
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            exp_out(img, ecnt, ers, ecd);
            row = (ecnt % FRAME) / ROWP;
            touched[row] = 1;
            if (!bad[row] && ({row_sel, col_data} !== {ers, ecd})) begin
                bad[row] = 1;
                fa[row]  = {row_sel, col_data};
                fe[row]  = {ers, ecd};
            end
        end
        for (int r = 0; r < 8; r++) begin
            if (touched[r]) begin
                n_cmp++;
                if (bad[r]) begin
                    n_fail++;
                    $display("FAIL %s row%0d {row_sel,col_data}: got %h expected %h", tag, r, fa[r], fe[r]);
                end
            end
        end
    endtask

    // Entered and left on a negedge; returns just after the last pixel edge
    task automatic send_stream(input img_t img, input int npix, input string tag);
        frame_start = 1'b1;
        pixel_data  = 4'd0;
        @(negedge clk);
        frame_start = 1'b0;
        cmp({tag, " busy after start"}, 64'(capture_busy), 64'd1);
        @(negedge clk);
        for (int k = 0; k < npix; k++) begin
            pixel_data = img[k*4 +: 4];
            @(negedge clk);
        end
        pixel_data = 4'd0;
    endtask

    task automatic wait_swap(input int budget, input string tag, output int e);
        e = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_swapped) begin
                e = ecnt;
                break;
            end
        end
        if (e < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s swap_wait: got no frame_swapped expected pulse within %0d clks", tag, budget);
        end else if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s swap_unexpected: got frame_swapped expected none queued", tag);
        end else begin
            shown = q.pop_front();
        end
    endtask

    task automatic wait_pos(input int val);
        int g = 0;
        while ((ecnt % FRAME) != val && g < 2 * FRAME) begin
            @(negedge clk);
            g++;
        end
        cmp("scan position reached", 64'(ecnt % FRAME), 64'(val));
    endtask

    initial begin
        vec_t vecs[12];
        img_t zero_img, img2, img_d, img_e, img_b, img_c, img_f, img_g, img_h, img_p, dummy;
        int   e_done, e_sw, sc, g, c0, c1, c2;

        vecs[0]  = '{0,   8'h00, 8'h00};
        vecs[1]  = '{1,   8'h01, 8'h00};
        vecs[2]  = '{64,  8'h01, 8'h00};
        vecs[3]  = '{65,  8'h00, 8'h00};
        vecs[4]  = '{66,  8'h02, 8'h00};
        vecs[5]  = '{130, 8'h00, 8'h00};
        vecs[6]  = '{131, 8'h04, 8'h00};
        vecs[7]  = '{196, 8'h08, 8'h00};
        vecs[8]  = '{456, 8'h80, 8'h00};
        vecs[9]  = '{519, 8'h80, 8'h00};
        vecs[10] = '{520, 8'h00, 8'h00};
        vecs[11] = '{521, 8'h01, 8'h00};

        zero_img = '0;
        img2 = '0;  img2[43*4 +: 4] = 4'h1;
        img_d = '0; img_e = '0; img_b = '0; img_c = '0;
        img_f = '0; img_g = '0; img_h = '0; img_p = '0;
        for (int k = 0; k < 64; k++) begin
            if (k % 3 == 0)           img_d[k*4 +: 4] = 4'hF;
            if (k % 5 == 1)           img_e[k*4 +: 4] = 4'h9;
            if (k % 9 == 0)           img_b[k*4 +: 4] = 4'h5;
            if (k < 8 || k >= 56)     img_c[k*4 +: 4] = 4'h3;
            img_f[k*4 +: 4] = 4'h2;
            if (k % 2 == 0)           img_g[k*4 +: 4] = 4'hC;
            img_h[k*4 +: 4] = 4'hF;
        end
        img_p[0*4 +: 4] = 4'd8;
        img_p[2*4 +: 4] = 4'd15;
        shown = '0;

        // Reset state
        rst_n = 1'b0; frame_start = 1'b0; pixel_data = 4'd0;
        repeat (3) @(negedge clk);
        cmp("reset row_sel",       64'(row_sel),       64'h00);
        cmp("reset col_data",      64'(col_data),      64'h00);
        cmp("reset frame_swapped", 64'(frame_swapped), 64'd0);
        cmp("reset capture_busy",  64'(capture_busy),  64'd0);
        rst_n = 1'b1;

        // Scan sequence after release, blank display
        foreach (vecs[i]) begin
            g = 0;
            while (ecnt < vecs[i].e && g < 2000) begin
                @(negedge clk);
                g++;
            end
            cmp($sformatf("scan vec edge %0d", vecs[i].e), {48'd0, row_sel, col_data}, {48'd0, vecs[i].rs, vecs[i].cd});
        end
        cmp("no swap after reset", 64'(swap_cnt), 64'd0);

        // Single pixel (x=3,y=5)
        sc = swap_cnt;
        send_stream(img2, 64, "t2");
        e_done = ecnt;
        q.push_back(img2);
        cmp("t2 busy after completion", 64'(capture_busy), 64'd0);
        wait_swap(FRAME + 100, "t2", e_sw);
        cmp("t2 swap on boundary", 64'(e_sw % FRAME), 64'd0);
        cmp("t2 swap within frame after completion", 64'(e_sw > e_done && e_sw - e_done <= FRAME), 64'd1);
        check_span(shown, FRAME, "t2");
        cmp("t2 swap count", 64'(swap_cnt - sc), 64'd1);

        // Abort at pixel 20, second stream wins
        sc = swap_cnt;
        send_stream(img_d, 20, "t3a");
        send_stream(img_e, 64, "t3b");
        e_done = ecnt;
        q.push_back(img_e);
        wait_swap(FRAME + 100, "t3", e_sw);
        cmp("t3 swap on boundary", 64'(e_sw % FRAME), 64'd0);
        cmp("t3 swap after second completion", 64'(e_sw > e_done && e_sw - e_done <= FRAME), 64'd1);
        check_span(shown, FRAME, "t3");
        cmp("t3 swap count", 64'(swap_cnt - sc), 64'd1);

        // Completion while row 3 is lit: rest of frame keeps old image
        wait_pos(154);
        sc = swap_cnt;
        send_stream(img_b, 64, "t4");
        q.push_back(img_b);
        cmp("t4 completion inside row 3", 64'((ecnt % FRAME) / ROWP), 64'd3);
        check_span(shown, (FRAME - 1) - (ecnt % FRAME), "t4 old");
        wait_swap(10, "t4", e_sw);
        cmp("t4 swap on boundary", 64'(e_sw % FRAME), 64'd0);
        check_span(shown, FRAME, "t4 new");
        cmp("t4 swap count", 64'(swap_cnt - sc), 64'd1);

        // Completion coincident with the boundary edge: deferred a frame
        wait_pos(FRAME - 66);
        send_stream(img_c, 64, "t4c");
        e_done = ecnt;
        cmp("t4c completion on boundary", 64'(e_done % FRAME), 64'd0);
        cmp("t4c no swap on completion edge", 64'(frame_swapped), 64'd0);
        q.push_back(img_c);
        wait_swap(FRAME + 10, "t4c", e_sw);
        cmp("t4c swap one frame later", 64'(e_sw - e_done), 64'(FRAME));
        check_span(shown, FRAME, "t4c");

        // Capture start on the boundary edge beats a pending swap
        send_stream(img_f, 64, "t4s");
        q.push_back(img_f);
        wait_pos(FRAME - 1);
        sc = swap_cnt;
        send_stream(img_g, 64, "t4g");
        cmp("t4s start beats swap", 64'(swap_cnt - sc), 64'd0);
        dummy = q.pop_back();
        q.push_back(img_g);
        wait_swap(FRAME + 10, "t4g", e_sw);
        cmp("t4g swap on boundary", 64'(e_sw % FRAME), 64'd0);
        check_span(shown, FRAME, "t4g");

        // Reset at pixel 30
        g = 0;
        while ((ecnt % ROWP) != 5 && g < 200) begin
            @(negedge clk);
            g++;
        end
        send_stream(img_h, 30, "t5");
        #2 rst_n = 1'b0;
        #1;
        cmp("t5 row_sel in reset",       64'(row_sel),       64'h00);
        cmp("t5 col_data in reset",      64'(col_data),      64'h00);
        cmp("t5 frame_swapped in reset", 64'(frame_swapped), 64'd0);
        cmp("t5 capture_busy in reset",  64'(capture_busy),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sc = swap_cnt;
        shown = zero_img;
        check_span(shown, 2 * FRAME, "t5 blank");
        cmp("t5 busy after release", 64'(capture_busy), 64'd0);
        cmp("t5 no swap after reset", 64'(swap_cnt - sc), 64'd0);

        // Intensity handling on row 0
        send_stream(img_p, 64, "t6");
        q.push_back(img_p);
        wait_swap(FRAME + 100, "t6", e_sw);
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (row_sel == 8'h01) begin
                c0 += int'(col_data[0]);
                c1 += int'(col_data[1]);
                c2 += int'(col_data[2]);
            end
        end
`ifdef MATRIX_PWM_EN
        cmp("t6 intensity 8 on-count",  64'(c0), 64'd32);
        cmp("t6 intensity 0 on-count",  64'(c1), 64'd0);
        cmp("t6 intensity 15 on-count", 64'(c2), 64'd60);
`else
        cmp("t6 intensity 8 on-count",  64'(c0), 64'd64);
        cmp("t6 intensity 0 on-count",  64'(c1), 64'd0);
        cmp("t6 intensity 15 on-count", 64'(c2), 64'd64);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
